mem_port_arbiter: RTL and testbench

// - Shares the single unified memory port between two requesters: the IF-stage

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester unified memory port arbiter (optional perf counters: MEM_ARB_PERF_EN)
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_be,
  input  logic                  m_gnt,
  input  logic                  m_rvalid,
  input  logic [DATA_W-1:0]     m_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_i_grants,
  output logic [31:0]           perf_d_grants,
  output logic [31:0]           perf_i_wait_cycles
`endif
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_owner_d;      // 1: D owns the current transaction, 0: I
  logic            w_owner_d_nxt;
  logic            r_store;        // current D transaction is a store (rdata forced to 0)
  logic            w_store_nxt;
  logic [SW-1:0]   r_streak;
  logic [SW-1:0]   w_streak_nxt;

  // State, owner lock, store flag and D streak registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_owner_d <= 1'b0;
      r_store   <= 1'b0;
      r_streak  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner_d <= w_owner_d_nxt;
      r_store   <= w_store_nxt;
      r_streak  <= w_streak_nxt;
    end
  end

  // Next-state, owner selection and all muxed outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_d_nxt = r_owner_d;
    w_store_nxt   = r_store;
    w_streak_nxt  = r_streak;
    i_gnt         = 1'b0;
    i_rvalid      = 1'b0;
    i_rdata       = '0;
    d_gnt         = 1'b0;
    d_rvalid      = 1'b0;
    d_rdata       = '0;
    m_req         = 1'b0;
    m_we          = 1'b0;
    m_addr        = '0;
    m_wdata       = '0;
    m_be          = '0;
    case (r_state)
      S_IDLE: begin
        if (d_req || i_req) begin
          w_state_nxt   = S_REQ;
          // D wins unless I is waiting and D has used up its streak
          w_owner_d_nxt = d_req && !(i_req && (r_streak == STREAK_MAX));
        end
      end
      S_REQ: begin
        m_req = 1'b1;
        if (r_owner_d) begin
          m_we    = d_we;
          m_addr  = d_addr;
          m_wdata = d_wdata;
          m_be    = d_be;
        end else begin
          m_addr  = i_addr;
          m_be    = '1;
        end
        if (m_gnt) begin
          w_state_nxt = S_WAIT;
          if (r_owner_d) begin
            d_gnt       = 1'b1;
            w_store_nxt = d_we;
            if (i_req)
              w_streak_nxt = (r_streak == STREAK_MAX) ? r_streak : r_streak + SW'(1);
            else
              w_streak_nxt = '0;
          end else begin
            i_gnt        = 1'b1;
            w_store_nxt  = 1'b0;
            w_streak_nxt = '0;
          end
        end
      end
      S_WAIT: begin
        if (m_rvalid) begin
          w_state_nxt = S_IDLE;
          if (r_owner_d) begin
            d_rvalid = 1'b1;
            d_rdata  = r_store ? '0 : m_rdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = m_rdata;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_i_grants;
  logic [31:0] r_perf_d_grants;
  logic [31:0] r_perf_i_wait;

  // Free-running wrap-around grant and fetch-wait counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_i_grants <= '0;
      r_perf_d_grants <= '0;
      r_perf_i_wait   <= '0;
    end else begin
      if (i_gnt)
        r_perf_i_grants <= r_perf_i_grants + 32'd1;
      if (d_gnt)
        r_perf_d_grants <= r_perf_d_grants + 32'd1;
      if (i_req && !i_gnt)
        r_perf_i_wait <= r_perf_i_wait + 32'd1;
    end
  end

  assign perf_i_grants      = r_perf_i_grants;
  assign perf_d_grants      = r_perf_d_grants;
  assign perf_i_wait_cycles = r_perf_i_wait;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_i_gnt"},    {31'd0, i_gnt},    32'd0);
    chk({tag, "_i_rvalid"}, {31'd0, i_rvalid}, 32'd0);
    chk({tag, "_i_rdata"},  i_rdata,           32'd0);
    chk({tag, "_d_gnt"},    {31'd0, d_gnt},    32'd0);
    chk({tag, "_d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
    chk({tag, "_d_rdata"},  d_rdata,           32'd0);
    chk({tag, "_m_req"},    {31'd0, m_req},    32'd0);
    chk({tag, "_m_we"},     {31'd0, m_we},     32'd0);
    chk({tag, "_m_addr"},   m_addr,            32'd0);
    chk({tag, "_m_wdata"},  m_wdata,           32'd0);
    chk({tag, "_m_be"},     {28'd0, m_be},     32'd0);
  endtask

  // One complete transaction: wait for m_req, hold off m_gnt for gnt_dly
  // cycles, grant, then respond one cycle later with rd.
  task automatic txn(input string tag, input bit exp_d, input logic [31:0] exp_addr,
                     input int gnt_dly, input logic [31:0] rd, input logic [31:0] exp_rd,
                     input bit drop_req);
    bit seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (m_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_m_req_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_m_addr"}, m_addr, exp_addr);
    for (int k = 0; k < gnt_dly; k++) begin
      @(negedge clk); #1;
      chk({tag, "_lock_m_addr"}, m_addr, exp_addr);
      chk({tag, "_lock_gnts"}, {30'd0, i_gnt, d_gnt}, 32'd0);
    end
    m_gnt = 1'b1;
    #1;
    chk({tag, "_gnt"}, {30'd0, i_gnt, d_gnt}, exp_d ? 32'd1 : 32'd2);
    @(negedge clk);
    m_gnt = 1'b0;
    if (drop_req) begin
      if (exp_d) d_req = 1'b0;
      else       i_req = 1'b0;
    end
    #1;
    chk({tag, "_wait_m_req"}, {31'd0, m_req}, 32'd0);
    chk({tag, "_wait_gnts"}, {30'd0, i_gnt, d_gnt}, 32'd0);
    @(negedge clk);
    m_rvalid = 1'b1;
    m_rdata  = rd;
    #1;
    chk({tag, "_rvalid"}, {30'd0, i_rvalid, d_rvalid}, exp_d ? 32'd1 : 32'd2);
    chk({tag, "_owner_rdata"}, exp_d ? d_rdata : i_rdata, exp_rd);
    chk({tag, "_other_rdata"}, exp_d ? i_rdata : d_rdata, 32'd0);
    @(negedge clk);
    m_rvalid = 1'b0;
    m_rdata  = '0;
    #1;
    chk({tag, "_rvalid_end"}, {30'd0, i_rvalid, d_rvalid}, 32'd0);
    chk({tag, "_bubble"}, {31'd0, m_req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // I only
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h100;
    #1;
    chk("ionly_idle_m_req", {31'd0, m_req}, 32'd0);
    txn("ionly", 1'b0, 32'h100, 1, 32'h00500093, 32'h00500093, 1'b1);

    // Simultaneous: D first, then I
    i_req = 1'b1; i_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_be = 4'hF;
    txn("sim_d", 1'b1, 32'h500, 0, 32'hAAAA5555, 32'hAAAA5555, 1'b1);
    txn("sim_i", 1'b0, 32'h400, 0, 32'h11112222, 32'h11112222, 1'b1);

    // Lock: I owns REQ, D arrives while m_gnt is held low
    i_req = 1'b1; i_addr = 32'h200;
    @(negedge clk); #1;
    chk("lock_owner_req", {31'd0, m_req}, 32'd1);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
    txn("lock_i", 1'b0, 32'h200, 5, 32'hCAFE0001, 32'hCAFE0001, 1'b1);
    txn("lock_d", 1'b1, 32'h300, 0, 32'h12345678, 32'h12345678, 1'b1);

    // Store ack
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h800; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    @(negedge clk); #1;
    chk("store_m_we", {31'd0, m_we}, 32'd1);
    chk("store_m_be", {28'd0, m_be}, 32'h3);
    chk("store_m_wdata", m_wdata, 32'hDEADBEEF);
    txn("store", 1'b1, 32'h800, 0, 32'hFFFFFFFF, 32'd0, 1'b1);

    // Starvation guard: 4 D stores, then I, then remaining D
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h600; d_wdata = 32'h0BADF00D; d_be = 4'hF;
    i_req = 1'b1; i_addr = 32'h700;
    txn("starve_d1", 1'b1, 32'h600, 0, 32'h1, 32'd0, 1'b0);
    txn("starve_d2", 1'b1, 32'h600, 0, 32'h2, 32'd0, 1'b0);
    txn("starve_d3", 1'b1, 32'h600, 0, 32'h3, 32'd0, 1'b0);
    txn("starve_d4", 1'b1, 32'h600, 0, 32'h4, 32'd0, 1'b0);
    txn("starve_i",  1'b0, 32'h700, 0, 32'h00000013, 32'h00000013, 1'b1);
    txn("starve_d5", 1'b1, 32'h600, 0, 32'h5, 32'd0, 1'b0);
    txn("starve_d6", 1'b1, 32'h600, 0, 32'h6, 32'd0, 1'b1);

    // Streak cleared: both request again and D must win
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'hB00;
    i_req = 1'b1; i_addr = 32'hC00;
    txn("clr_d", 1'b1, 32'hB00, 0, 32'h77, 32'h77, 1'b1);
    txn("clr_i", 1'b0, 32'hC00, 0, 32'h88, 32'h88, 1'b1);

    // Reset in WAIT, stray response dropped
    i_req = 1'b1; i_addr = 32'h900;
    @(negedge clk); #1;
    chk("rstw_m_req", {31'd0, m_req}, 32'd1);
    m_gnt = 1'b1;
    #1;
    chk("rstw_i_gnt", {31'd0, i_gnt}, 32'd1);
    @(negedge clk);
    m_gnt = 1'b0; i_req = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("rstw_in_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_rvalid = 1'b1; m_rdata = 32'h5;
    #1;
    chk_all_zero("rstw_stray");
    @(negedge clk);
    m_rvalid = 1'b0; m_rdata = '0;
    #1;
    chk("rstw_idle_m_req", {31'd0, m_req}, 32'd0);
    i_req = 1'b1; i_addr = 32'hA00;
    txn("post_rst", 1'b0, 32'hA00, 0, 32'h00100073, 32'h00100073, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
